uart_sram_loader: RTL

UART_SRAM_LOADER -- requirements
Module: uart_sram_loader

---
 rtl/uart_sram_loader.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_sram_loader.sv
// Loads WORDS words from a parallel-bus UART into asynchronous SRAM, then reads them back and
// echoes every byte over the UART (little-endian byte order within each word).
module uart_sram_loader #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 20,
    parameter int unsigned WORDS     = 4,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned WAIT_CYC  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W:0]     word_cnt,
    output logic                uart_rdn,
    output logic                uart_wrn,
    input  logic                uart_dataready,
    input  logic                uart_tbre,
    input  logic                uart_tsre,
    input  logic [7:0]          uart_d_i,
    output logic [7:0]          uart_d_o,
    output logic                uart_d_oe,
    output logic [ADDR_W-1:0]   ram_addr,
    input  logic [DATA_W-1:0]   ram_d_i,
    output logic [DATA_W-1:0]   ram_d_o,
    output logic                ram_d_oe,
    output logic                ram_ce_n,
    output logic                ram_oe_n,
    output logic                ram_we_n,
    output logic [DATA_W/8-1:0] ram_be_n
);

    localparam int unsigned NB = DATA_W / 8;
    localparam int unsigned KW = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned CW = $clog2(WAIT_CYC + 2);

    // One-hot so every strobe is taken straight from a single state flop.
    localparam int unsigned I_IDLE    = 0;
    localparam int unsigned I_RX_WAIT = 1;
    localparam int unsigned I_RX_RD   = 2;
    localparam int unsigned I_WR      = 3;
    localparam int unsigned I_WR_HOLD = 4;
    localparam int unsigned I_RD      = 5;
    localparam int unsigned I_TX_LOAD = 6;
    localparam int unsigned I_TX_WR   = 7;
    localparam int unsigned I_TX_TBRE = 8;
    localparam int unsigned I_TX_TSRE = 9;
    localparam int unsigned I_DONE    = 10;

    localparam logic [10:0] S_IDLE    = 11'(1) << I_IDLE;
    localparam logic [10:0] S_RX_WAIT = 11'(1) << I_RX_WAIT;
    localparam logic [10:0] S_RX_RD   = 11'(1) << I_RX_RD;
    localparam logic [10:0] S_WR      = 11'(1) << I_WR;
    localparam logic [10:0] S_WR_HOLD = 11'(1) << I_WR_HOLD;
    localparam logic [10:0] S_RD      = 11'(1) << I_RD;
    localparam logic [10:0] S_TX_LOAD = 11'(1) << I_TX_LOAD;
    localparam logic [10:0] S_TX_WR   = 11'(1) << I_TX_WR;
    localparam logic [10:0] S_TX_TBRE = 11'(1) << I_TX_TBRE;
    localparam logic [10:0] S_TX_TSRE = 11'(1) << I_TX_TSRE;
    localparam logic [10:0] S_DONE    = 11'(1) << I_DONE;

    localparam logic [KW-1:0]     K_LAST    = KW'(NB - 1);
    localparam logic [ADDR_W-1:0] W_LAST    = ADDR_W'(WORDS - 1);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [CW-1:0]     CYC_LAST  = CW'(WAIT_CYC - 1);
    localparam logic [CW-1:0]     RD_LAST   = CW'(1);
    localparam logic [ADDR_W:0]   WCNT_ONE  = (ADDR_W + 1)'(1);

    logic [10:0]       r_state, w_state_d;
    logic [KW-1:0]     r_k, w_k_d;
    logic [ADDR_W-1:0] r_widx, w_widx_d;
    logic [CW-1:0]     r_cyc, w_cyc_d;
    logic [DATA_W-1:0] r_word, w_word_d;
    logic [ADDR_W:0]   r_wcnt, w_wcnt_d;
    logic [ADDR_W-1:0] w_addr;

    assign w_addr = BASE + r_widx;

    always_comb begin
        w_state_d = r_state;
        w_k_d     = r_k;
        w_widx_d  = r_widx;
        w_cyc_d   = r_cyc;
        w_word_d  = r_word;
        w_wcnt_d  = r_wcnt;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_d = S_RX_WAIT;
                    w_k_d     = '0;
                    w_widx_d  = '0;
                    w_wcnt_d  = '0;
                end
            end
            S_RX_WAIT: begin
                if (uart_dataready) begin
                    w_state_d = S_RX_RD;
                    w_cyc_d   = '0;
                end
            end
            S_RX_RD: begin
                if (r_cyc == RD_LAST) begin
                    w_word_d[{r_k, 3'b000} +: 8] = uart_d_i;
                    w_cyc_d = '0;
                    if (r_k == K_LAST) begin
                        w_state_d = S_WR;
                    end else begin
                        w_k_d     = r_k + KW'(1);
                        w_state_d = S_RX_WAIT;
                    end
                end else begin
                    w_cyc_d = r_cyc + CW'(1);
                end
            end
            S_WR: begin
                if (r_cyc == CYC_LAST) begin
                    w_state_d = S_WR_HOLD;
                end else begin
                    w_cyc_d = r_cyc + CW'(1);
                end
            end
            S_WR_HOLD: begin
                w_wcnt_d = r_wcnt + WCNT_ONE;
                w_cyc_d  = '0;
                w_k_d    = '0;
                if (r_widx == W_LAST) begin
                    w_widx_d  = '0;
                    w_state_d = S_RD;
                end else begin
                    w_widx_d  = r_widx + ADDR_W'(1);
                    w_state_d = S_RX_WAIT;
                end
            end
            S_RD: begin
                if (r_cyc == CYC_LAST) begin
                    w_word_d  = ram_d_i;
                    w_k_d     = '0;
                    w_state_d = S_TX_LOAD;
                end else begin
                    w_cyc_d = r_cyc + CW'(1);
                end
            end
            S_TX_LOAD: w_state_d = S_TX_WR;
            S_TX_WR:   w_state_d = S_TX_TBRE;
            S_TX_TBRE: begin
                if (uart_tbre) w_state_d = S_TX_TSRE;
            end
            S_TX_TSRE: begin
                if (uart_tsre) begin
                    if (r_k != K_LAST) begin
                        w_k_d     = r_k + KW'(1);
                        w_state_d = S_TX_LOAD;
                    end else if (r_widx != W_LAST) begin
                        w_widx_d  = r_widx + ADDR_W'(1);
                        w_cyc_d   = '0;
                        w_state_d = S_RD;
                    end else begin
                        w_state_d = S_DONE;
                    end
                end
            end
            S_DONE:  w_state_d = S_IDLE;
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_widx  <= '0;
            r_cyc   <= '0;
            r_word  <= '0;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_state_d;
            r_k     <= w_k_d;
            r_widx  <= w_widx_d;
            r_cyc   <= w_cyc_d;
            r_word  <= w_word_d;
            r_wcnt  <= w_wcnt_d;
        end
    end

    always_comb begin
        busy      = ~r_state[I_IDLE];
        done      = r_state[I_DONE];
        word_cnt  = r_wcnt;
        uart_rdn  = ~r_state[I_RX_RD];
        uart_wrn  = ~r_state[I_TX_WR];
        uart_d_oe = r_state[I_TX_LOAD] | r_state[I_TX_WR];
        uart_d_o  = uart_d_oe ? r_word[{r_k, 3'b000} +: 8] : 8'h00;
        ram_ce_n  = ~(r_state[I_WR] | r_state[I_RD]);
        ram_we_n  = ~r_state[I_WR];
        ram_oe_n  = ~r_state[I_RD];
        ram_d_oe  = r_state[I_WR] | r_state[I_WR_HOLD];
        ram_d_o   = ram_d_oe ? r_word : '0;
        ram_addr  = (r_state[I_WR] | r_state[I_WR_HOLD] | r_state[I_RD]) ? w_addr : '0;
        ram_be_n  = '0;
    end

endmodule
